// File: rtl/rbcounter_ctrl.sv
// Command sequencer for the 4-bit ripple T-flip-flop counter: issues clear/tick strobes,
// waits out the ripple settle window, samples the count and reports it with a done pulse.
module rbcounter_ctrl #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_arg_i,
  output logic             cnt_clr_o,
  output logic             cnt_t_o,
  output logic             cnt_tick_o,
  input  logic [WIDTH-1:0] cnt_q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] count_out_o
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SettleLast = SW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH:0] TickLimit  = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {OpClear = 2'd0, OpStep = 2'd1, OpRunTo = 2'd2, OpRsvd = 2'd3} op_e;
  typedef enum logic [2:0] {StIdle, StClear, StTick, StSettle, StCheck, StDone} state_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   ticks_q;
  logic [SW-1:0]    settle_q;
  logic [WIDTH-1:0] q_smp_q;
  logic             ready_q, busy_q, done_q, err_q, clr_q, t_q, tick_q;
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpClear;
      arg_q    <= '0;
      rem_q    <= '0;
      ticks_q  <= '0;
      settle_q <= '0;
      q_smp_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clr_q    <= 1'b0;
      t_q      <= 1'b0;
      tick_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q     <= op_e'(cmd_op_i);
            arg_q    <= cmd_arg_i;
            rem_q    <= cmd_arg_i;
            ticks_q  <= '0;
            settle_q <= SettleLast;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            unique case (op_e'(cmd_op_i))
              OpClear: begin
                state_q <= StClear;
                clr_q   <= 1'b1;
              end
              OpStep: begin
                t_q <= 1'b1;
                if (cmd_arg_i != '0) begin
                  state_q <= StTick;
                  tick_q  <= 1'b1;
                end else begin
                  state_q <= StSettle;
                end
              end
              OpRunTo: begin
                t_q     <= 1'b1;
                state_q <= StSettle;
              end
              default: begin
                state_q <= StDone;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        StClear: begin
          settle_q <= SettleLast;
          state_q  <= StSettle;
        end
        StTick: begin
          rem_q    <= rem_q - WIDTH'(1);
          ticks_q  <= ticks_q + (WIDTH+1)'(1);
          settle_q <= SettleLast;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == '0) begin
            q_smp_q <= cnt_q_i;
            if (op_q == OpStep && rem_q != '0) begin
              state_q <= StTick;
              tick_q  <= 1'b1;
            end else begin
              state_q <= StCheck;
            end
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        StCheck: begin
          count_q <= q_smp_q;
          unique case (op_q)
            OpClear: begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= (q_smp_q != '0);
            end
            OpRunTo: begin
              if (q_smp_q == arg_q || ticks_q == TickLimit) begin
                state_q <= StDone;
                done_q  <= 1'b1;
                err_q   <= (q_smp_q != arg_q);
              end else begin
                count_q <= count_q;
                state_q <= StTick;
                tick_q  <= 1'b1;
              end
            end
            default: begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end
          endcase
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          t_q     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cnt_clr_o   = clr_q;
  assign cnt_t_o     = t_q;
  assign cnt_tick_o  = tick_q;
  assign count_out_o = count_q;

endmodule

// File: tb/tb_rbcounter_ctrl.sv
// Directed bench for rbcounter_ctrl with a behavioural ripple-counter model and fault injection.
module tb_rbcounter_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       cmd_ready_o, cnt_clr_o, cnt_t_o, cnt_tick_o, busy_o, done_o, err_o;
  logic [3:0] count_out_o;
  logic [3:0] cnt_model = 4'd0;
  logic       stuck_en = 1'b0;
  logic [3:0] stuck_val = 4'd0;
  logic [3:0] cnt_q;

  int passed = 0, total = 0;
  int tick_cnt = 0, clr_cnt = 0, done_cnt = 0, overlap = 0;
  int cyc = 0, acc_n = 0, acc_prev = 0, acc_last = 0;

  always #5 clk_i = ~clk_i;

  assign cnt_q = stuck_en ? stuck_val : cnt_model;

  rbcounter_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i   (cmd_op),
    .cmd_arg_i  (cmd_arg),
    .cnt_clr_o  (cnt_clr_o),
    .cnt_t_o    (cnt_t_o),
    .cnt_tick_o (cnt_tick_o),
    .cnt_q_i    (cnt_q),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .count_out_o(count_out_o)
  );

  // Ripple counter model: advances on the falling edge of tick when toggling is enabled.
  always @(negedge cnt_tick_o or posedge cnt_clr_o) begin
    if (cnt_clr_o) cnt_model <= 4'd0;
    else if (cnt_t_o) cnt_model <= cnt_model + 4'd1;
  end

  always @(posedge cnt_tick_o) tick_cnt++;
  always @(posedge cnt_clr_o) clr_cnt++;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (done_o && cmd_ready_o) overlap++;
  end

  always @(posedge clk_i) begin
    cyc++;
    if (cmd_valid && cmd_ready_o && rst_ni) begin
      acc_prev = acc_last;
      acc_last = cyc;
      acc_n++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] arg, output int lat);
    int guard = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    tick_cnt = 0;
    clr_cnt  = 0;
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(posedge clk_i);
      if (c > 1) #1;
      if (done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    bit         stuck;
    logic [3:0] stuck_val;
    int         lat;
    int         ticks;
    int         clrs;
    int         count;
    int         err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int done_before;
    int guard;

    vecs[0]  = '{2'd0, 4'd0,  1'b0, 4'd0, 5,  0,  1, 0,  0};  // CLEAR after reset
    vecs[1]  = '{2'd1, 4'd3,  1'b0, 4'd0, 11, 3,  0, 3,  0};  // STEP 3
    vecs[2]  = '{2'd1, 4'd0,  1'b0, 4'd0, 4,  0,  0, 3,  0};  // STEP 0
    vecs[3]  = '{2'd2, 4'd14, 1'b0, 4'd0, 48, 11, 0, 14, 0};  // RUN_TO 14 from 3
    vecs[4]  = '{2'd1, 4'd3,  1'b0, 4'd0, 11, 3,  0, 1,  0};  // wrap 14 -> 1
    vecs[5]  = '{2'd0, 4'd0,  1'b0, 4'd0, 5,  0,  1, 0,  0};
    vecs[6]  = '{2'd1, 4'd2,  1'b0, 4'd0, 8,  2,  0, 2,  0};
    vecs[7]  = '{2'd2, 4'd6,  1'b0, 4'd0, 20, 4,  0, 6,  0};  // RUN_TO 6 from 2
    vecs[8]  = '{2'd2, 4'd6,  1'b0, 4'd0, 4,  0,  0, 6,  0};  // already there
    vecs[9]  = '{2'd3, 4'd9,  1'b0, 4'd0, 1,  0,  0, 6,  1};  // reserved op
    vecs[10] = '{2'd1, 4'd1,  1'b0, 4'd0, 5,  1,  0, 7,  0};
    vecs[11] = '{2'd2, 4'd5,  1'b0, 4'd0, 60, 14, 0, 5,  0};  // RUN_TO through wrap
    vecs[12] = '{2'd2, 4'd9,  1'b1, 4'd5, 68, 16, 0, 5,  1};  // stuck at 5
    vecs[13] = '{2'd0, 4'd0,  1'b1, 4'd3, 5,  0,  1, 3,  1};  // stuck at 3

    // Reset values
    #12;
    check("rst ready", int'(cmd_ready_o), 1);
    check("rst busy", int'(busy_o), 0);
    check("rst done", int'(done_o), 0);
    check("rst err", int'(err_o), 0);
    check("rst clr", int'(cnt_clr_o), 0);
    check("rst t", int'(cnt_t_o), 0);
    check("rst tick", int'(cnt_tick_o), 0);
    check("rst count", int'(count_out_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset asserted mid-STEP 5, while a tick is high
    @(negedge clk_i);
    cmd_op = 2'd1;
    cmd_arg = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    check("mid tick high", int'(cnt_tick_o), 1);
    done_before = done_cnt;
    rst_ni = 1'b0;
    #1;
    check("abort tick", int'(cnt_tick_o), 0);
    check("abort t", int'(cnt_t_o), 0);
    check("abort busy", int'(busy_o), 0);
    check("abort ready", int'(cmd_ready_o), 1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("abort no done", done_cnt, done_before);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      stuck_en = vecs[i].stuck;
      stuck_val = vecs[i].stuck_val;
      do_cmd(vecs[i].op, vecs[i].arg, lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d ticks", i), tick_cnt, vecs[i].ticks);
      check($sformatf("v%0d clears", i), clr_cnt, vecs[i].clrs);
      check($sformatf("v%0d count_out", i), int'(count_out_o), vecs[i].count);
      check($sformatf("v%0d err", i), int'(err_o), vecs[i].err);
    end
    @(negedge clk_i);
    stuck_en = 1'b0;

    // cmd_valid held high across a whole command: second accept only after done
    @(negedge clk_i);
    while (!cmd_ready_o) @(negedge clk_i);
    acc_n = 0;
    cmd_op = 2'd1;
    cmd_arg = 4'd2;
    cmd_valid = 1'b1;
    guard = 0;
    while (acc_n < 2 && guard < 60) begin
      @(negedge clk_i);
      guard++;
    end
    cmd_valid = 1'b0;
    check("hold accepts", acc_n, 2);
    check("hold accept gap", acc_last - acc_prev, 9);
    repeat (20) @(negedge clk_i);
    check("hold no extra accept", acc_n, 2);
    check("hold count_out", int'(count_out_o), 4);
    check("done/ready overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
